// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state enum, command/reply byte codes, sensor_cmd encodings,
// the reply payload struct and the command-decode helpers.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SCMD_W = 2;
    localparam int unsigned ADDR_W = 5;

    localparam int unsigned DEF_N_SENSORS    = 32;
    localparam int unsigned DEF_BYTE_TIMEOUT = 2304;
    localparam int unsigned DEF_SENSOR_TMO   = 65535;
    localparam int unsigned DEF_REPEAT_TICKS = 115200;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_CHECK,
        ST_REQ,
        ST_WAIT_SENS,
        ST_SEND_CODE,
        ST_WAIT_CODE,
        ST_SEND_VAL,
        ST_WAIT_VAL
    } state_e;

    // Command bytes received from the host
    localparam logic [BYTE_W-1:0] CMD_STATUS    = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_TEMP      = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_HUM       = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_CONT_TEMP = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_CONT_HUM  = 8'h05;
    localparam logic [BYTE_W-1:0] CMD_STOP      = 8'h06;

    // Reply bytes sent back to the host
    localparam logic [BYTE_W-1:0] RPL_ERR       = 8'h1F;
    localparam logic [BYTE_W-1:0] RPL_SENS_TMO  = 8'hFE;
    localparam logic [BYTE_W-1:0] RPL_SENS_FAIL = 8'hFF;
    localparam logic [BYTE_W-1:0] RPL_STOP_VAL  = 8'h00;

    typedef enum logic [SCMD_W-1:0] {
        SCMD_STATUS = 2'd0,
        SCMD_TEMP   = 2'd1,
        SCMD_HUM    = 2'd2
    } scmd_e;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic [BYTE_W-1:0] value;
    } reply_t;

    // Commands that result in a sensor request
    function automatic logic is_sensor_cmd(input logic [BYTE_W-1:0] cmd);
        return (cmd >= CMD_STATUS) && (cmd <= CMD_CONT_HUM);
    endfunction

    function automatic logic is_cont_cmd(input logic [BYTE_W-1:0] cmd);
        return (cmd == CMD_CONT_TEMP) || (cmd == CMD_CONT_HUM);
    endfunction

    function automatic scmd_e cmd_to_scmd(input logic [BYTE_W-1:0] cmd);
        scmd_e s;
        case (cmd)
            CMD_TEMP, CMD_CONT_TEMP: s = SCMD_TEMP;
            CMD_HUM,  CMD_CONT_HUM:  s = SCMD_HUM;
            default:                 s = SCMD_STATUS;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/byte_holding_reg.sv
// Receiver byte intake: edge-detects rx_done, buffers one byte, flags overrun.
// Ports: clk_115200hz/reset (sync, active-low); rx_data/rx_done from the
// receiver; pop consumes the held byte; hold_valid/hold_data present it;
// rx_overrun is sticky until reset.
module byte_holding_reg
    import uart_cmd_pkg::*;
(
    input  logic              clk_115200hz,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              pop,
    output logic              hold_valid,
    output logic [BYTE_W-1:0] hold_data,
    output logic              rx_overrun
);

    logic rx_done_q;
    logic rx_rise_c;

    assign rx_rise_c = rx_done && !rx_done_q;

    // A byte arriving on the same edge the FSM pops is accepted, not dropped
    always_ff @(posedge clk_115200hz) begin
        if (!reset) begin
            rx_done_q  <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            if (rx_rise_c) begin
                if (!hold_valid || pop) begin
                    hold_valid <= 1'b1;
                    hold_data  <= rx_data;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames 2-byte host commands, issues sensor requests and returns 2-byte replies.
// Ports: clk_115200hz/reset (sync, active-low); rx_data/rx_done from receiver;
// tx_data/tx_start/tx_busy to transmitter; sensor_req/cmd/addr and
// sensor_done/ok/val to the sensor interface; cont_active shows continuous
// mode; rx_overrun is the sticky dropped-byte flag.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned N_SENSORS    = DEF_N_SENSORS,
    parameter int unsigned BYTE_TIMEOUT = DEF_BYTE_TIMEOUT,
    parameter int unsigned SENSOR_TMO   = DEF_SENSOR_TMO,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic              clk_115200hz,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              sensor_req,
    output logic [SCMD_W-1:0] sensor_cmd,
    output logic [ADDR_W-1:0] sensor_addr,
    input  logic              sensor_done,
    input  logic              sensor_ok,
    input  logic [BYTE_W-1:0] sensor_val,
    output logic              cont_active,
    output logic              rx_overrun
);

    localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned ST_W = $clog2(SENSOR_TMO + 1);
    localparam int unsigned PT_W = $clog2(REPEAT_TICKS + 1);

    logic              hold_valid;
    logic [BYTE_W-1:0] hold_data;
    logic              pop_c;

    byte_holding_reg u_hold (
        .clk_115200hz (clk_115200hz),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .pop          (pop_c),
        .hold_valid   (hold_valid),
        .hold_data    (hold_data),
        .rx_overrun   (rx_overrun)
    );

    state_e            state_q,     state_d;
    logic [BYTE_W-1:0] cmd_q,       cmd_d;
    logic [BYTE_W-1:0] addr_q,      addr_d;
    reply_t            reply_q,     reply_d;
    logic [BYTE_W-1:0] cont_cmd_q,  cont_cmd_d;
    logic [BYTE_W-1:0] cont_addr_q, cont_addr_d;
    logic [BT_W-1:0]   byte_tmr_q,  byte_tmr_d;
    logic [ST_W-1:0]   sens_tmr_q,  sens_tmr_d;
    logic [PT_W-1:0]   per_tmr_q,   per_tmr_d;
    logic [1:0]        wait_cnt_q,  wait_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic              tx_start_d;
    logic              sensor_req_d;
    logic [SCMD_W-1:0] sensor_cmd_d;
    logic [ADDR_W-1:0] sensor_addr_d;
    logic              cont_active_d;
    logic              repeat_due_c;

    assign repeat_due_c = cont_active && (per_tmr_q == PT_W'(REPEAT_TICKS - 1));

    // State, timers and all outputs
    always_ff @(posedge clk_115200hz) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            reply_q     <= '0;
            cont_cmd_q  <= '0;
            cont_addr_q <= '0;
            byte_tmr_q  <= '0;
            sens_tmr_q  <= '0;
            per_tmr_q   <= '0;
            wait_cnt_q  <= '0;
            seen_busy_q <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            sensor_req  <= 1'b0;
            sensor_cmd  <= '0;
            sensor_addr <= '0;
            cont_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            reply_q     <= reply_d;
            cont_cmd_q  <= cont_cmd_d;
            cont_addr_q <= cont_addr_d;
            byte_tmr_q  <= byte_tmr_d;
            sens_tmr_q  <= sens_tmr_d;
            per_tmr_q   <= per_tmr_d;
            wait_cnt_q  <= wait_cnt_d;
            seen_busy_q <= seen_busy_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            sensor_req  <= sensor_req_d;
            sensor_cmd  <= sensor_cmd_d;
            sensor_addr <= sensor_addr_d;
            cont_active <= cont_active_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        reply_d       = reply_q;
        cont_cmd_d    = cont_cmd_q;
        cont_addr_d   = cont_addr_q;
        byte_tmr_d    = byte_tmr_q;
        sens_tmr_d    = sens_tmr_q;
        wait_cnt_d    = wait_cnt_q;
        seen_busy_d   = seen_busy_q;
        tx_data_d     = tx_data;
        tx_start_d    = 1'b0;
        sensor_req_d  = 1'b0;
        sensor_cmd_d  = sensor_cmd;
        sensor_addr_d = sensor_addr;
        cont_active_d = cont_active;
        pop_c         = 1'b0;

        // Period timer saturates so a repeat deferred by a received byte still fires
        per_tmr_d = per_tmr_q;
        if (cont_active && !repeat_due_c) begin
            per_tmr_d = per_tmr_q + PT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_valid) begin
                    pop_c      = 1'b1;
                    cmd_d      = hold_data;
                    byte_tmr_d = '0;
                    state_d    = ST_GET_ADDR;
                end else if (repeat_due_c) begin
                    cmd_d   = cont_cmd_q;
                    addr_d  = cont_addr_q;
                    state_d = ST_REQ;
                end
            end
            ST_GET_ADDR: begin
                if (hold_valid) begin
                    pop_c   = 1'b1;
                    addr_d  = hold_data;
                    state_d = ST_CHECK;
                end else if (byte_tmr_q == BT_W'(BYTE_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    byte_tmr_d = byte_tmr_q + BT_W'(1);
                end
            end
            ST_CHECK: begin
                if (cmd_q == CMD_STOP) begin
                    cont_active_d = 1'b0;
                    reply_d       = '{code: CMD_STOP, value: RPL_STOP_VAL};
                    state_d       = ST_SEND_CODE;
                end else if (is_sensor_cmd(cmd_q) && (32'(addr_q) < N_SENSORS)) begin
                    cont_active_d = is_cont_cmd(cmd_q);
                    if (is_cont_cmd(cmd_q)) begin
                        cont_cmd_d  = cmd_q;
                        cont_addr_d = addr_q;
                    end
                    state_d = ST_REQ;
                end else begin
                    reply_d = '{code: RPL_ERR, value: cmd_q};
                    state_d = ST_SEND_CODE;
                end
            end
            ST_REQ: begin
                sensor_req_d  = 1'b1;
                sensor_cmd_d  = cmd_to_scmd(cmd_q);
                sensor_addr_d = addr_q[ADDR_W-1:0];
                sens_tmr_d    = '0;
                per_tmr_d     = '0;
                state_d       = ST_WAIT_SENS;
            end
            ST_WAIT_SENS: begin
                if (sensor_done) begin
                    if (sensor_ok) begin
                        reply_d = '{code: cmd_q, value: sensor_val};
                    end else begin
                        reply_d = '{code: RPL_ERR, value: RPL_SENS_FAIL};
                    end
                    state_d = ST_SEND_CODE;
                end else if (sens_tmr_q == ST_W'(SENSOR_TMO - 1)) begin
                    reply_d = '{code: RPL_ERR, value: RPL_SENS_TMO};
                    state_d = ST_SEND_CODE;
                end else begin
                    sens_tmr_d = sens_tmr_q + ST_W'(1);
                end
            end
            ST_SEND_CODE, ST_SEND_VAL: begin
                if (!tx_busy) begin
                    tx_data_d   = (state_q == ST_SEND_CODE) ? reply_q.code : reply_q.value;
                    tx_start_d  = 1'b1;
                    wait_cnt_d  = '0;
                    seen_busy_d = 1'b0;
                    state_d     = (state_q == ST_SEND_CODE) ? ST_WAIT_CODE : ST_WAIT_VAL;
                end
            end
            ST_WAIT_CODE, ST_WAIT_VAL: begin
                // Byte is done after busy falls, or if busy never rose within 2 cycles
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q || (wait_cnt_q == 2'd2)) begin
                    state_d = (state_q == ST_WAIT_CODE) ? ST_SEND_VAL : ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer with behavioural transmitter and sensor models.
module tb_uart_cmd_sequencer;

    localparam int unsigned N_SENSORS    = 32;
    localparam int unsigned BYTE_TIMEOUT = 50;
    localparam int unsigned SENSOR_TMO   = 300;
    localparam int unsigned REPEAT_TICKS = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       sensor_req;
    logic [1:0] sensor_cmd;
    logic [4:0] sensor_addr;
    logic       sensor_done = 1'b0;
    logic       sensor_ok = 1'b0;
    logic [7:0] sensor_val = 8'h00;
    logic       cont_active;
    logic       rx_overrun;

    uart_cmd_sequencer #(
        .N_SENSORS    (N_SENSORS),
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .SENSOR_TMO   (SENSOR_TMO),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk_115200hz (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .sensor_req   (sensor_req),
        .sensor_cmd   (sensor_cmd),
        .sensor_addr  (sensor_addr),
        .sensor_done  (sensor_done),
        .sensor_ok    (sensor_ok),
        .sensor_val   (sensor_val),
        .cont_active  (cont_active),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: logs each started byte and stays busy for 8 cycles
    logic [7:0] tx_log[$];
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
        if (tx_start) begin
            check("tx_start_while_busy", int'(tx_busy), 0);
            tx_log.push_back(tx_data);
            busy_cnt = 8;
            tx_busy  = 1'b1;
        end
    end

    // Sensor model: mode 0 answers ok, 1 answers not-ok, 2 never answers
    int         s_mode = 0;
    logic [7:0] s_val = 8'h00;
    int         s_dly = 0;
    int         req_cnt = 0;
    int         req_cyc[$];
    logic [1:0] last_cmd = 2'd3;
    logic [4:0] last_addr = 5'd0;

    always @(negedge clk) begin
        sensor_done = 1'b0;
        if (s_dly > 0) begin
            s_dly--;
            if (s_dly == 0) begin
                sensor_done = 1'b1;
                sensor_ok   = (s_mode == 0);
                sensor_val  = s_val;
            end
        end
        if (sensor_req) begin
            req_cnt++;
            req_cyc.push_back(cyc);
            last_cmd  = sensor_cmd;
            last_addr = sensor_addr;
            if (s_mode != 2) s_dly = 3;
        end
    end

    function automatic int txb(input int i);
        if (i < tx_log.size()) return int'(tx_log[i]);
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_req(input int target, input int budget);
        int k = 0;
        while (req_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        int         mode;
        logic [7:0] sval;
        bit         exp_req;
        logic [1:0] exp_scmd;
        logic [4:0] exp_saddr;
        logic [7:0] exp_code;
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int r0;
        int ok;

        vecs[0] = '{8'h02, 8'h03, 0, 8'h19, 1'b1, 2'd1, 5'd3,  8'h02, 8'h19};
        vecs[1] = '{8'h09, 8'h00, 0, 8'h00, 1'b0, 2'd0, 5'd0,  8'h1F, 8'h09};
        vecs[2] = '{8'h01, 8'd40, 0, 8'h00, 1'b0, 2'd0, 5'd0,  8'h1F, 8'h01};
        vecs[3] = '{8'h03, 8'h01, 2, 8'h00, 1'b1, 2'd2, 5'd1,  8'h1F, 8'hFE};
        vecs[4] = '{8'h03, 8'h01, 1, 8'h00, 1'b1, 2'd2, 5'd1,  8'h1F, 8'hFF};
        vecs[5] = '{8'h01, 8'h1F, 0, 8'h5A, 1'b1, 2'd0, 5'd31, 8'h01, 8'h5A};
        vecs[6] = '{8'h02, 8'h20, 0, 8'h00, 1'b0, 2'd0, 5'd0,  8'h1F, 8'h02};
        vecs[7] = '{8'h00, 8'h00, 0, 8'h00, 1'b0, 2'd0, 5'd0,  8'h1F, 8'h00};
        vecs[8] = '{8'h06, 8'h00, 0, 8'h00, 1'b0, 2'd0, 5'd0,  8'h06, 8'h00};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_sensor_req", int'(sensor_req), 0);
        check("rst_sensor_cmd", int'(sensor_cmd), 0);
        check("rst_sensor_addr", int'(sensor_addr), 0);
        check("rst_cont_active", int'(cont_active), 0);
        check("rst_rx_overrun", int'(rx_overrun), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven single commands
        for (int i = 0; i < 9; i++) begin
            s_mode = vecs[i].mode;
            s_val  = vecs[i].sval;
            tx_log.delete();
            r0 = req_cnt;
            send_byte(vecs[i].cmd);
            send_byte(vecs[i].addr);
            wait_tx(2, SENSOR_TMO + 300);
            repeat (30) @(negedge clk);
            check($sformatf("v%0d_tx_count", i), tx_log.size(), 2);
            check($sformatf("v%0d_code", i), txb(0), int'(vecs[i].exp_code));
            check($sformatf("v%0d_value", i), txb(1), int'(vecs[i].exp_val));
            check($sformatf("v%0d_req_count", i), req_cnt - r0, vecs[i].exp_req ? 1 : 0);
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d_req_cmd", i), int'(last_cmd), int'(vecs[i].exp_scmd));
                check($sformatf("v%0d_req_addr", i), int'(last_addr), int'(vecs[i].exp_saddr));
                check($sformatf("v%0d_cmd_held", i), int'(sensor_cmd), int'(vecs[i].exp_scmd));
                check($sformatf("v%0d_addr_held", i), int'(sensor_addr), int'(vecs[i].exp_saddr));
            end
        end

        // Missing ADDR byte times out silently; next pair is a fresh command
        s_mode = 0;
        s_val  = 8'h33;
        tx_log.delete();
        r0 = req_cnt;
        send_byte(8'h02);
        repeat (BYTE_TIMEOUT + 10) @(negedge clk);
        check("bto_silent_tx", tx_log.size(), 0);
        check("bto_silent_req", req_cnt - r0, 0);
        send_byte(8'h03);
        send_byte(8'h00);
        wait_tx(2, 200);
        repeat (30) @(negedge clk);
        check("bto_fresh_code", txb(0), 8'h03);
        check("bto_fresh_value", txb(1), 8'h33);
        check("bto_fresh_cmd", int'(last_cmd), 2);
        check("bto_fresh_addr", int'(last_addr), 0);

        // Continuous temperature on sensor 2
        s_val = 8'h44;
        tx_log.delete();
        req_cyc.delete();
        r0 = req_cnt;
        send_byte(8'h04);
        send_byte(8'h02);
        repeat (350) @(negedge clk);
        check("cont_active_set", int'(cont_active), 1);
        check("cont_reqs_ge3", int'(req_cnt - r0 >= 3), 1);
        ok = (req_cyc.size() >= 2) ? int'((req_cyc[1] - req_cyc[0] >= 99) && (req_cyc[1] - req_cyc[0] <= 103)) : 0;
        check("cont_period", ok, 1);
        check("cont_code", txb(0), 8'h04);
        check("cont_value", txb(1), 8'h44);
        check("cont_repeat_code", txb(2), 8'h04);
        check("cont_req_cmd", int'(last_cmd), 1);
        check("cont_req_addr", int'(last_addr), 2);

        // Stop continuous mode in the gap between periodic replies
        r0 = req_cnt;
        wait_req(r0 + 1, 200);
        repeat (40) @(negedge clk);
        tx_log.delete();
        send_byte(8'h06);
        send_byte(8'h00);
        wait_tx(2, 200);
        repeat (20) @(negedge clk);
        check("stop_code", txb(0), 8'h06);
        check("stop_value", txb(1), 8'h00);
        check("stop_cont_clear", int'(cont_active), 0);
        r0 = req_cnt;
        repeat (300) @(negedge clk);
        check("stop_no_reqs", req_cnt - r0, 0);
        check("stop_no_tx", tx_log.size(), 2);

        // Overrun: three bytes while waiting on a silent sensor
        check("ovr_clear_before", int'(rx_overrun), 0);
        s_mode = 2;
        tx_log.delete();
        r0 = req_cnt;
        send_byte(8'h02);
        send_byte(8'h01);
        wait_req(r0 + 1, 100);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("ovr_set", int'(rx_overrun), 1);
        wait_tx(2, SENSOR_TMO + 300);
        check("ovr_tmo_code", txb(0), 8'h1F);
        check("ovr_tmo_value", txb(1), 8'hFE);
        repeat (100) @(negedge clk);
        check("ovr_sticky", int'(rx_overrun), 1);
        check("ovr_no_extra_tx", tx_log.size(), 2);

        // Reset while waiting on the CODE byte
        s_mode = 0;
        s_val  = 8'h77;
        tx_log.delete();
        send_byte(8'h04);
        send_byte(8'h05);
        wait_tx(1, 200);
        check("mid_cont_before", int'(cont_active), 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_tx_data", int'(tx_data), 0);
        check("mid_tx_start", int'(tx_start), 0);
        check("mid_sensor_req", int'(sensor_req), 0);
        check("mid_sensor_cmd", int'(sensor_cmd), 0);
        check("mid_sensor_addr", int'(sensor_addr), 0);
        check("mid_cont_active", int'(cont_active), 0);
        check("mid_rx_overrun", int'(rx_overrun), 0);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_no_value_byte", tx_log.size(), 1);
        tx_log.delete();
        send_byte(8'h09);
        send_byte(8'h00);
        wait_tx(2, 200);
        repeat (20) @(negedge clk);
        check("post_rst_code", txb(0), 8'h1F);
        check("post_rst_value", txb(1), 8'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
